// File: rtl/dpram_128x8_fifo_ctrl.sv
// Push/pop FIFO controller that drives the dpram_128x8 memory tile.
// The RAM's registered data_out becomes a read stream qualified by rd_valid.
module dpram_128x8_fifo_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 7,
  parameter int AFULL_THRESH  = 120,
  parameter int AEMPTY_THRESH = 8
) (
  input  logic                  clk,
  input  logic                  R,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH+1)'(1 << ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic                  push_acc;
  logic                  pop_acc;

  // Flags come from the registered count only; a same-cycle pop never frees room for a push.
  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AFULL_C);
  assign almost_empty = (count <= AEMPTY_C);

  assign push_acc = push & ~full;
  assign pop_acc  = pop & ~empty;

  assign mem_wen     = push_acc;
  assign mem_waddr   = wptr;
  assign mem_data_in = push_data;
  assign mem_ren     = pop_acc;
  assign mem_raddr   = rptr;

  // The RAM output register only loads on ren, so it already holds the last word read.
  assign rd_data = mem_data_out;

  // NOTE: non-blocking assignments so every register samples pre-edge values of its peers.
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_acc) wptr <= wptr + 1'b1;
      if (pop_acc)  rptr <= rptr + 1'b1;
      case ({push_acc, pop_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      rd_valid  <= pop_acc;
      overflow  <= overflow  | (push & full);
      underflow <= underflow | (pop & empty);
    end
  end

endmodule
